mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit that runs beside the single-cycle ALU and executes the RV32M operation set.
- Operands enter over a valid/ready handshake. Results leave over a second valid/ready handshake.
- Takes one operation at a time, one bit per cycle, so area stays small. Divide-by-zero and signed overflow finish on a 1-cycle fast path.
- Has a flush input so the pipeline can squash an in-flight operation on redirect.

Parameters:
WIDTH, 32, operand and result width in bits; must be >= 4 and a power of two
CNT_W, $clog2(WIDTH), iteration counter width (derived; do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of any accepted or in-flight operation
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
op  input  3  operation = funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
input1  input  WIDTH  rs1 operand (multiplicand / dividend)
input2  input  WIDTH  rs2 operand (multiplier / divisor)
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  WIDTH  final result

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, all datapath registers 0.
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE). It is combinational from state only.
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid&&in_ready, latch op and the operands.
  - Signed ops latch operand magnitudes:
    - MULH: both operands signed.
    - MULHSU: rs1 signed only.
    - DIV, REM: both operands signed.
  - Latch the result-sign flags: neg_prod, neg_quot, neg_rem (neg_rem = dividend sign).
  - Special divide cases go straight to DONE with the result loaded:
    - input2==0: DIV/DIVU -> all-ones; REM/REMU -> input1.
    - DIV/REM with input1==1<<(WIDTH-1) and input2==all-ones: DIV -> input1; REM -> 0.
  - Any other op -> BUSY with counter=WIDTH-1.
- BUSY:
  - One iteration per cycle, WIDTH cycles total.
  - Multiply: shift-add on a 2*WIDTH accumulator, consuming LSB-first.
  - Divide: restoring, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
  - When counter==0, apply the sign fix (two's-complement negate if the flag is set), select the half or part, register result, and go to DONE. Otherwise decrement counter.
  - Result selection:
    - MUL: low WIDTH bits.
    - MULH/MULHSU/MULHU: high WIDTH bits of the signed-corrected 2*WIDTH product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
- Latency:
  - Normal ops: accept at cycle 0, out_valid high at cycle WIDTH+1.
  - Special cases: out_valid high at cycle 1.
- DONE:
  - result and out_valid hold stable while out_ready=0.
  - On out_ready=1 -> IDLE; in_ready rises the next cycle.
  - No accept in the same cycle as the output handshake.
- flush:
  - Highest priority over every other event. Any state -> IDLE next cycle; out_valid=0 next cycle.
  - A request presented in the same cycle as flush is not accepted.
  - result is not cleared; it is ignored once out_valid=0.
- Reset mid-operation: all state is abandoned immediately (asynchronous), reset values apply, and no stale out_valid follows.
- Width rules:
  - The 2*WIDTH product is exact, with no truncation before selection.
  - Magnitude of 1<<(WIDTH-1) is represented unsigned in WIDTH bits.
  - Negation is mod 2^WIDTH or mod 2^(2*WIDTH) as appropriate.
- X-safety: outputs never depend on input1/input2/op except via registers latched at accept.

Decomposition:
- Shared package mdu_pkg:
  - op localparams: OP_MUL..OP_REMU.
  - state encoding: IDLE/BUSY/DONE.
  - helper functions is_div(op), is_signed_rs1(op), is_signed_rs2(op).
- Sub-module mdu_sign_fix:
  - Purely combinational, parametrised by width.
  - Conditional two's-complement negate; also used for the abs at accept.
  - Instantiated at WIDTH for accept and at 2*WIDTH for the product.

Test Plan:
- WIDTH=32, MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both 1-cycle latency; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0, 1-cycle latency.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0; release -> handshake, in_ready=1 the following cycle; a second op then completes correctly.
- Flush at BUSY iteration 10 -> out_valid never rises, in_ready=1 next cycle; also pull rst_n low mid-BUSY between clock edges -> outputs at reset values immediately, no out_valid after release.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM state encoding and opcode-class helpers for the iterative MDU.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mdu_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_rs1(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_rs2(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; serves as abs() at accept and as the final sign fix.
module mdu_sign_fix #(
  parameter int unsigned Width = 32
) (
  input  logic             neg_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  always_comb begin
    data_o = neg_i ? (~data_i + 1'b1) : data_i;
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, 1-cycle fast path for
// divide-by-zero and signed overflow, valid/ready on both sides, synchronous flush.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] IntMin = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;        // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;    // product, or dividend/quotient in the low half
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_prod_q, neg_prod_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               sgn1, sgn2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic               div_zero, div_ovf;

  assign sgn1     = is_signed_rs1(op) & input1[WIDTH-1];
  assign sgn2     = is_signed_rs2(op) & input2[WIDTH-1];
  assign div_zero = is_div(op) && (input2 == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (input1 == IntMin) && (input2 == '1);

  mdu_sign_fix #(.Width(WIDTH)) u_abs1 (.neg_i(sgn1), .data_i(input1), .data_o(abs1));
  mdu_sign_fix #(.Width(WIDTH)) u_abs2 (.neg_i(sgn2), .data_i(input2), .data_o(abs2));

  // Multiply step: conditional add into the high half, then shift the whole accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step; the extra top bit of the difference is the borrow.
  logic [WIDTH+1:0] trial, diff;
  logic             borrow;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quot_nxt;
  assign trial    = {rem_q, acc_q[WIDTH-1]};
  assign diff     = trial - {2'b00, a_q};
  assign borrow   = diff[WIDTH+1];
  assign rem_nxt  = borrow ? trial[WIDTH:0] : diff[WIDTH:0];
  assign quot_nxt = {acc_q[WIDTH-2:0], ~borrow};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_sel, div_fix;
  logic               div_neg;
  assign div_sel = op_q[1] ? rem_nxt[WIDTH-1:0] : quot_nxt;
  assign div_neg = op_q[1] ? neg_rem_q : neg_quot_q;

  mdu_sign_fix #(.Width(2*WIDTH)) u_prod_fix (
    .neg_i (neg_prod_q),
    .data_i(mul_nxt),
    .data_o(prod_fix)
  );
  mdu_sign_fix #(.Width(WIDTH)) u_div_fix (.neg_i(div_neg), .data_i(div_sel), .data_o(div_fix));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_prod_d = neg_prod_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_d       = op;
            neg_prod_d = sgn1 ^ sgn2;
            neg_quot_d = sgn1 ^ sgn2;
            neg_rem_d  = sgn1;
            if (div_zero) begin
              result_d = op[1] ? input1 : '1;
              state_d  = StDone;
            end else if (div_ovf) begin
              result_d = op[1] ? '0 : input1;
              state_d  = StDone;
            end else begin
              a_d     = is_div(op) ? abs2 : abs1;
              acc_d   = {{WIDTH{1'b0}}, (is_div(op) ? abs1 : abs2)};
              rem_d   = '0;
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = StBusy;
            end
          end
        end
        StBusy: begin
          if (is_div(op_q)) begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], quot_nxt};
            rem_d = rem_nxt;
          end else begin
            acc_d = mul_nxt;
          end
          if (cnt_q == '0) begin
            if (is_div(op_q)) begin
              result_d = div_fix;
            end else if (op_q == OP_MUL) begin
              result_d = prod_fix[WIDTH-1:0];
            end else begin
              result_d = prod_fix[2*WIDTH-1:WIDTH];
            end
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_prod_q <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_prod_q <= neg_prod_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule
